// File: rtl/issue_queue_pkg.sv
// Shared constants, types and helpers for the out-of-order issue queue.
package issue_queue_pkg;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NPHYS  = 64;
  localparam int TAG_W  = $clog2(NPHYS);
  localparam int DATA_W = 32;
  localparam int PKT_W  = 167;
  localparam int REGS_W = NPHYS * DATA_W;

  // Field positions inside the decoded issue packet
  localparam int OPB_LSB     = 135;
  localparam int SHAMT_LSB   = 130;
  localparam int NEXT_LSB    = 98;
  localparam int LINK_BIT    = 97;
  localparam int REGDST_BIT  = 96;
  localparam int JUMP_BIT    = 95;
  localparam int BRANCH_BIT  = 94;
  localparam int MEMRD_BIT   = 93;
  localparam int MEMWR_BIT   = 92;
  localparam int HASIMM_BIT  = 91;
  localparam int REGWR_BIT   = 90;
  localparam int JREG_BIT    = 89;
  localparam int SIGNEXT_BIT = 88;
  localparam int SYS_BIT     = 87;
  localparam int ALUCON_LSB  = 81;
  localparam int HILO_LSB    = 79;
  localparam int PC_LSB      = 47;
  localparam int INSTR_LSB   = 15;
  localparam int RS_LSB      = 10;
  localparam int RT_LSB      = 5;
  localparam int RD_LSB      = 0;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PKT_W-1:0] pkt_t;

  // One queue slot: the packet plus per-source readiness
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] num;
    pkt_t              pkt;
    tag_t              tag_a;
    tag_t              tag_b;
    tag_t              tag_c;
    logic              rdy_a;
    logic              rdy_b;
    logic              rdy_c;
  } entry_t;

  // Everything registered toward EXE
  typedef struct packed {
    tag_t              regwr;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [4:0]        shamt;
    logic [5:0]        alucon;
    logic [1:0]        hilo;
    logic              regwr_flag;
    logic              memwr;
    logic              memrd;
    logic              branch;
    logic              jump;
    logic              jreg;
    logic              regdst;
    logic              link;
    logic              sys;
    logic              alusrc;
    logic [DATA_W-1:0] alt_pc;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] mwd;
    logic [4:0]        arch_a;
    logic [4:0]        arch_b;
    logic [4:0]        arch_c;
    logic [DATA_W-1:0] num;
  } exe_out_t;

  // A broadcast only counts when valid and not targeting the hardwired zero register
  function automatic logic bcast_hit(input logic bvalid, input tag_t bmap, input tag_t tag);
    return bvalid && (bmap != '0) && (bmap == tag);
  endfunction

  // Readiness of a source at allocation time
  function automatic logic enq_ready(input tag_t tag, input logic [NPHYS-1:0] busy,
                                     input logic eb, input tag_t em,
                                     input logic mb, input tag_t mm);
    return (tag == '0) || !busy[tag] || bcast_hit(eb, em, tag) || bcast_hit(mb, mm, tag);
  endfunction

  // Operand read with same-cycle forwarding, EXE result preferred over MEM
  function automatic logic [DATA_W-1:0] read_val(input tag_t tag,
                                                 input logic eb, input tag_t em,
                                                 input logic [DATA_W-1:0] ev,
                                                 input logic mb, input tag_t mm,
                                                 input logic [DATA_W-1:0] mv,
                                                 input logic [REGS_W-1:0] regs);
    if (tag == '0)                   return '0;
    else if (bcast_hit(eb, em, tag)) return ev;
    else if (bcast_hit(mb, mm, tag)) return mv;
    else                             return regs[int'(tag)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/issue_queue_select.sv
// Oldest-first picker: lowest sequence number among eligible slots, ties to lower index.
module issue_select
  import issue_queue_pkg::*;
(
  input  logic [DEPTH-1:0]             eligible,
  input  logic [DEPTH-1:0][DATA_W-1:0] instr_num,
  output logic [IDX_W-1:0]             sel_idx,
  output logic                         found
);

  logic [DATA_W-1:0] best;

  // Linear scan; strict less-than keeps the earlier index on equal numbers
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    best    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!found || (instr_num[i] < best))) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
        best    = instr_num[i];
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Issue queue between Rename and EXE: buffers renamed instructions, wakes sources on
// result broadcasts and issues the oldest ready one per cycle with operands attached.
module issue_queue
  import issue_queue_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic               rename_enque,
  input  logic [31:0]        rename_instr_num,
  input  logic [PKT_W-1:0]   rename_issueinfo,
  input  logic [NPHYS-1:0]   busy,
  input  logic [TAG_W-1:0]   rename_A,
  input  logic [TAG_W-1:0]   rename_B,
  input  logic [TAG_W-1:0]   rename_C,
  input  logic               exe_broadcast,
  input  logic [TAG_W-1:0]   exe_broadcast_map,
  input  logic [31:0]        exe_broadcast_val,
  input  logic               mem_broadcast,
  input  logic [TAG_W-1:0]   mem_broadcast_map,
  input  logic [31:0]        mem_broadcast_val,
  input  logic [REGS_W-1:0]  PhysReg,
  input  logic [31:0]        rob_instr_num,
  output logic [TAG_W-1:0]   RegWr_exe,
  output logic [31:0]        instr_exe,
  output logic [31:0]        instr_pc_exe,
  output logic [4:0]         shamt_exe,
  output logic [5:0]         ALU_con_exe,
  output logic [1:0]         hilo_exe,
  output logic               RegWr_flag_exe,
  output logic               MemWr_exe,
  output logic               MemRd_exe,
  output logic               branch_exe,
  output logic               jump_exe,
  output logic               jumpReg_exe,
  output logic               regDest_exe,
  output logic               link_exe,
  output logic               sys_exe,
  output logic               ALUSrc_exe,
  output logic [31:0]        alt_PC_exe,
  output logic [31:0]        operandA1_exe,
  output logic [31:0]        operandB1_exe,
  output logic [31:0]        MemWriteData_exe,
  output logic [4:0]         A_exe,
  output logic [4:0]         B_exe,
  output logic [4:0]         C_exe,
  output logic [31:0]        instr_num_exe,
  output logic               halt_rename
);

  entry_t [DEPTH-1:0]             ent_q, ent_d;
  exe_out_t                       out_q, out_d;
  logic [DEPTH-1:0]               eligible;
  logic [DEPTH-1:0][DATA_W-1:0]   ent_num;
  logic [IDX_W-1:0]               sel_idx;
  logic                           found;
  logic                           do_issue;
  logic [IDX_W-1:0]               free_idx;
  logic                           free_found;
  entry_t                         sel_ent;
  pkt_t                           sel_pkt;
  logic [DATA_W-1:0]              val_a, val_b, val_c;
  logic                           unused_bits;

  // A slot may issue once A is ready and B/C are ready whenever the packet consumes them
  always_comb begin
    eligible = '0;
    ent_num  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_num[i]  = ent_q[i].num;
      eligible[i] = ent_q[i].valid && ent_q[i].rdy_a
                 && (ent_q[i].rdy_b || !ent_q[i].pkt[REGDST_BIT])
                 && (ent_q[i].rdy_c || !ent_q[i].pkt[MEMWR_BIT]);
    end
  end

  issue_select u_select (
    .eligible  (eligible),
    .instr_num (ent_num),
    .sel_idx   (sel_idx),
    .found     (found)
  );

  // Lowest-index slot that is empty at the start of the cycle receives the new instruction
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign halt_rename = !free_found;
  assign do_issue    = found && !STALL && !FLUSH;

  assign sel_ent = ent_q[sel_idx];
  assign sel_pkt = sel_ent.pkt;
  assign val_a   = read_val(sel_ent.tag_a, exe_broadcast, exe_broadcast_map, exe_broadcast_val,
                            mem_broadcast, mem_broadcast_map, mem_broadcast_val, PhysReg);
  assign val_b   = read_val(sel_ent.tag_b, exe_broadcast, exe_broadcast_map, exe_broadcast_val,
                            mem_broadcast, mem_broadcast_map, mem_broadcast_val, PhysReg);
  assign val_c   = read_val(sel_ent.tag_c, exe_broadcast, exe_broadcast_map, exe_broadcast_val,
                            mem_broadcast, mem_broadcast_map, mem_broadcast_val, PhysReg);

  // Queue state update: flush, otherwise wakeup, free the issued slot and allocate
  always_comb begin
    ent_d = ent_q;
    if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].rdy_a = 1'b0;
        ent_d[i].rdy_b = 1'b0;
        ent_d[i].rdy_c = 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid) begin
          if (bcast_hit(exe_broadcast, exe_broadcast_map, ent_q[i].tag_a) ||
              bcast_hit(mem_broadcast, mem_broadcast_map, ent_q[i].tag_a))
            ent_d[i].rdy_a = 1'b1;
          if (bcast_hit(exe_broadcast, exe_broadcast_map, ent_q[i].tag_b) ||
              bcast_hit(mem_broadcast, mem_broadcast_map, ent_q[i].tag_b))
            ent_d[i].rdy_b = 1'b1;
          if (bcast_hit(exe_broadcast, exe_broadcast_map, ent_q[i].tag_c) ||
              bcast_hit(mem_broadcast, mem_broadcast_map, ent_q[i].tag_c))
            ent_d[i].rdy_c = 1'b1;
        end
      end
      if (do_issue)
        ent_d[sel_idx].valid = 1'b0;
      if (rename_enque && free_found) begin
        ent_d[free_idx].valid = 1'b1;
        ent_d[free_idx].num   = rename_instr_num;
        ent_d[free_idx].pkt   = rename_issueinfo;
        ent_d[free_idx].tag_a = rename_A;
        ent_d[free_idx].tag_b = rename_B;
        ent_d[free_idx].tag_c = rename_C;
        ent_d[free_idx].rdy_a = enq_ready(rename_A, busy, exe_broadcast, exe_broadcast_map,
                                          mem_broadcast, mem_broadcast_map);
        ent_d[free_idx].rdy_b = enq_ready(rename_B, busy, exe_broadcast, exe_broadcast_map,
                                          mem_broadcast, mem_broadcast_map);
        ent_d[free_idx].rdy_c = enq_ready(rename_C, busy, exe_broadcast, exe_broadcast_map,
                                          mem_broadcast, mem_broadcast_map);
      end
    end
  end

  // EXE-side register: flush zeroes, stall holds, otherwise issue or bubble
  always_comb begin
    out_d = out_q;
    if (FLUSH) begin
      out_d = '0;
    end else if (!STALL) begin
      out_d = '0;
      if (found) begin
        out_d.regwr      = sel_ent.tag_c;
        out_d.instr      = sel_pkt[INSTR_LSB +: 32];
        out_d.pc         = sel_pkt[PC_LSB +: 32];
        out_d.shamt      = sel_pkt[SHAMT_LSB +: 5];
        out_d.alucon     = sel_pkt[ALUCON_LSB +: 6];
        out_d.hilo       = sel_pkt[HILO_LSB +: 2];
        out_d.regwr_flag = sel_pkt[REGWR_BIT] && (sel_pkt[RD_LSB +: 5] != 5'd0);
        out_d.memwr      = sel_pkt[MEMWR_BIT];
        out_d.memrd      = sel_pkt[MEMRD_BIT];
        out_d.branch     = sel_pkt[BRANCH_BIT];
        out_d.jump       = sel_pkt[JUMP_BIT];
        out_d.jreg       = sel_pkt[JREG_BIT];
        out_d.regdst     = sel_pkt[REGDST_BIT];
        out_d.link       = sel_pkt[LINK_BIT];
        out_d.sys        = sel_pkt[SYS_BIT];
        out_d.alusrc     = sel_pkt[HASIMM_BIT];
        out_d.alt_pc     = sel_pkt[NEXT_LSB +: 32];
        out_d.opa        = val_a;
        if (sel_pkt[BRANCH_BIT] && sel_pkt[LINK_BIT])
          out_d.opb = sel_pkt[OPB_LSB +: 32];
        else if (sel_pkt[REGDST_BIT])
          out_d.opb = val_b;
        else
          out_d.opb = sel_pkt[OPB_LSB +: 32];
        out_d.mwd        = val_c;
        out_d.arch_a     = sel_pkt[RS_LSB +: 5];
        out_d.arch_b     = sel_pkt[RT_LSB +: 5];
        out_d.arch_c     = sel_pkt[RD_LSB +: 5];
        out_d.num        = sel_ent.num;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ent_q <= '0;
      out_q <= '0;
    end else begin
      ent_q <= ent_d;
      out_q <= out_d;
    end
  end

  assign RegWr_exe        = out_q.regwr;
  assign instr_exe        = out_q.instr;
  assign instr_pc_exe     = out_q.pc;
  assign shamt_exe        = out_q.shamt;
  assign ALU_con_exe      = out_q.alucon;
  assign hilo_exe         = out_q.hilo;
  assign RegWr_flag_exe   = out_q.regwr_flag;
  assign MemWr_exe        = out_q.memwr;
  assign MemRd_exe        = out_q.memrd;
  assign branch_exe       = out_q.branch;
  assign jump_exe         = out_q.jump;
  assign jumpReg_exe      = out_q.jreg;
  assign regDest_exe      = out_q.regdst;
  assign link_exe         = out_q.link;
  assign sys_exe          = out_q.sys;
  assign ALUSrc_exe       = out_q.alusrc;
  assign alt_PC_exe       = out_q.alt_pc;
  assign operandA1_exe    = out_q.opa;
  assign operandB1_exe    = out_q.opb;
  assign MemWriteData_exe = out_q.mwd;
  assign A_exe            = out_q.arch_a;
  assign B_exe            = out_q.arch_b;
  assign C_exe            = out_q.arch_c;
  assign instr_num_exe    = out_q.num;

  // ROB head number and the sign-extend bit are carried but not needed at this stage
  assign unused_bits = ^{rob_instr_num, sel_pkt[SIGNEXT_BIT], sel_ent.valid,
                         sel_ent.rdy_a, sel_ent.rdy_b, sel_ent.rdy_c};

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: stimulus pushes expected issues, a monitor pops on each new issue.
module tb_issue_queue;

  typedef struct packed {
    logic [5:0]  regwr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  shamt;
    logic [5:0]  alucon;
    logic [1:0]  hilo;
    logic [9:0]  flags;
    logic [31:0] alt_pc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] mwd;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    logic [31:0] num;
  } exe_t;

  localparam logic [10:0] K_LINK   = 11'h400;
  localparam logic [10:0] K_REGDST = 11'h200;
  localparam logic [10:0] K_BRANCH = 11'h080;
  localparam logic [10:0] K_MEMWR  = 11'h020;
  localparam logic [10:0] K_IMM    = 11'h010;
  localparam logic [10:0] K_REGWR  = 11'h008;

  logic          CLK = 1'b0;
  logic          RESET, STALL, FLUSH, rename_enque;
  logic [31:0]   rename_instr_num;
  logic [166:0]  rename_issueinfo;
  logic [63:0]   busy;
  logic [5:0]    rename_A, rename_B, rename_C;
  logic          exe_broadcast, mem_broadcast;
  logic [5:0]    exe_broadcast_map, mem_broadcast_map;
  logic [31:0]   exe_broadcast_val, mem_broadcast_val;
  logic [2047:0] PhysReg;
  logic [31:0]   rob_instr_num;
  logic [5:0]    RegWr_exe;
  logic [31:0]   instr_exe, instr_pc_exe;
  logic [4:0]    shamt_exe;
  logic [5:0]    ALU_con_exe;
  logic [1:0]    hilo_exe;
  logic          RegWr_flag_exe, MemWr_exe, MemRd_exe, branch_exe, jump_exe, jumpReg_exe;
  logic          regDest_exe, link_exe, sys_exe, ALUSrc_exe;
  logic [31:0]   alt_PC_exe, operandA1_exe, operandB1_exe, MemWriteData_exe;
  logic [4:0]    A_exe, B_exe, C_exe;
  logic [31:0]   instr_num_exe;
  logic          halt_rename;

  int   total = 0;
  int   bad   = 0;
  exe_t sb[$];
  exe_t dut_out;
  exe_t last_out = '0;

  always #5 CLK = ~CLK;

  issue_queue dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .rename_enque(rename_enque), .rename_instr_num(rename_instr_num),
    .rename_issueinfo(rename_issueinfo), .busy(busy),
    .rename_A(rename_A), .rename_B(rename_B), .rename_C(rename_C),
    .exe_broadcast(exe_broadcast), .mem_broadcast(mem_broadcast),
    .exe_broadcast_map(exe_broadcast_map), .mem_broadcast_map(mem_broadcast_map),
    .exe_broadcast_val(exe_broadcast_val), .mem_broadcast_val(mem_broadcast_val),
    .PhysReg(PhysReg), .rob_instr_num(rob_instr_num),
    .RegWr_exe(RegWr_exe), .instr_exe(instr_exe), .instr_pc_exe(instr_pc_exe),
    .shamt_exe(shamt_exe), .ALU_con_exe(ALU_con_exe), .hilo_exe(hilo_exe),
    .RegWr_flag_exe(RegWr_flag_exe), .MemWr_exe(MemWr_exe), .MemRd_exe(MemRd_exe),
    .branch_exe(branch_exe), .jump_exe(jump_exe), .jumpReg_exe(jumpReg_exe),
    .regDest_exe(regDest_exe), .link_exe(link_exe), .sys_exe(sys_exe),
    .ALUSrc_exe(ALUSrc_exe), .alt_PC_exe(alt_PC_exe), .operandA1_exe(operandA1_exe),
    .operandB1_exe(operandB1_exe), .MemWriteData_exe(MemWriteData_exe),
    .A_exe(A_exe), .B_exe(B_exe), .C_exe(C_exe),
    .instr_num_exe(instr_num_exe), .halt_rename(halt_rename)
  );

  assign dut_out = {RegWr_exe, instr_exe, instr_pc_exe, shamt_exe, ALU_con_exe, hilo_exe,
                    {RegWr_flag_exe, MemWr_exe, MemRd_exe, branch_exe, jump_exe, jumpReg_exe,
                     regDest_exe, link_exe, sys_exe, ALUSrc_exe},
                    alt_PC_exe, operandA1_exe, operandB1_exe, MemWriteData_exe,
                    A_exe, B_exe, C_exe, instr_num_exe};

  // Pack the decoded fields into the 167-bit issue packet
  function automatic logic [166:0] mk_pkt(input logic [31:0] opb, input logic [4:0] shamt,
                                          input logic [31:0] nxt, input logic [10:0] ctl,
                                          input logic [5:0] alucon, input logic [1:0] hilo,
                                          input logic [31:0] pc, input logic [31:0] instr,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
    return {opb, shamt, nxt, ctl, alucon, hilo, pc, instr, rs, rt, rd};
  endfunction

  // Expected EXE bundle: copied fields from the packet, hand-computed operands and flag
  function automatic exe_t mk_exp(input logic [166:0] p, input logic [31:0] num,
                                  input logic [5:0] tagc, input logic [31:0] opa,
                                  input logic [31:0] opb, input logic [31:0] mwd,
                                  input logic flag);
    exe_t e;
    e.regwr  = tagc;
    e.instr  = p[46:15];
    e.pc     = p[78:47];
    e.shamt  = p[134:130];
    e.alucon = p[86:81];
    e.hilo   = p[80:79];
    e.flags  = {flag, p[92], p[93], p[94], p[95], p[89], p[96], p[97], p[87], p[91]};
    e.alt_pc = p[129:98];
    e.opa    = opa;
    e.opb    = opb;
    e.mwd    = mwd;
    e.a      = p[14:10];
    e.b      = p[9:5];
    e.c      = p[4:0];
    e.num    = num;
    return e;
  endfunction

  // One comparison, counted, with a FAIL line on disagreement
  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Present one instruction to rename for a single cycle (call just after a negedge)
  task automatic applyStimulus(input logic [166:0] p, input logic [31:0] num,
                               input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    rename_enque     = 1'b1;
    rename_issueinfo = p;
    rename_instr_num = num;
    rename_A         = a;
    rename_B         = b;
    rename_C         = c;
    @(negedge CLK);
    rename_enque     = 1'b0;
  endtask

  // Bounded wait until the scoreboard has drained down to 'target' entries
  task automatic waitQueue(input int target, input int budget);
    int n = 0;
    while (sb.size() > target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() > target) begin
      total++;
      bad++;
      $display("[TB] FAIL issue_timeout act=%0d exp=%0d", sb.size(), target);
    end
  endtask

  task automatic setReg(input int idx, input logic [31:0] v);
    PhysReg[idx*32 +: 32] = v;
  endtask

  // Monitor: every new non-bubble output is one issue and must match the scoreboard head
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET && dut_out != '0 && dut_out != last_out) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_issue act=%0h exp=none", dut_out);
        end else begin
          checkOutput($sformatf("issue_num%0d", sb[0].num), dut_out, sb[0]);
          void'(sb.pop_front());
        end
      end
      last_out = dut_out;
    end
  end

  // Watchdog against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog act=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [166:0] p_addu, p_i10, p_i11, p_full, p_drop, p_st, p_jal, p_nx, p_w, p_r;
  exe_t         e_jal;

  // Directed scenario sequence
  initial begin
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0; rename_enque = 1'b0;
    rename_instr_num = '0; rename_issueinfo = '0; busy = '0;
    rename_A = '0; rename_B = '0; rename_C = '0;
    exe_broadcast = 1'b0; exe_broadcast_map = '0; exe_broadcast_val = '0;
    mem_broadcast = 1'b0; mem_broadcast_map = '0; mem_broadcast_val = '0;
    PhysReg = '0; rob_instr_num = '0;
    setReg(5, 32'd3); setReg(6, 32'd4); setReg(12, 32'h12);

    repeat (2) @(negedge CLK);
    checkOutput("reset_halt", 512'(halt_rename), 512'(0));
    checkOutput("reset_out", 512'(dut_out), 512'(0));
    RESET = 1'b1;
    @(negedge CLK);

    // addu with both sources ready
    p_addu = mk_pkt(32'h77, 5'd7, 32'h404, K_REGDST | K_REGWR, 6'h21, 2'b01,
                    32'h400, 32'h00a61821, 5'd5, 5'd6, 5'd3);
    sb.push_back(mk_exp(p_addu, 32'd1, 6'd12, 32'd3, 32'd4, 32'h12, 1'b1));
    applyStimulus(p_addu, 32'd1, 6'd5, 6'd6, 6'd12);
    waitQueue(0, 20);

    // Older instr 10 waits on tag 7; younger 11 overtakes it, then a broadcast wakes 10
    busy[7] = 1'b1;
    p_i10 = mk_pkt(32'h10, 5'd0, 32'h40c, K_IMM | K_REGWR, 6'h09, 2'b00,
                   32'h408, 32'h24220010, 5'd1, 5'd2, 5'd0);
    p_i11 = mk_pkt(32'h20, 5'd0, 32'h410, K_IMM | K_REGWR, 6'h09, 2'b10,
                   32'h40c, 32'h24040020, 5'd0, 5'd2, 5'd4);
    sb.push_back(mk_exp(p_i11, 32'd11, 6'd21, 32'd0, 32'h20, 32'd0, 1'b1));
    sb.push_back(mk_exp(p_i10, 32'd10, 6'd20, 32'hAB, 32'h10, 32'd0, 1'b0));
    applyStimulus(p_i10, 32'd10, 6'd7, 6'd0, 6'd20);
    applyStimulus(p_i11, 32'd11, 6'd0, 6'd0, 6'd21);
    waitQueue(1, 20);
    repeat (2) @(negedge CLK);
    setReg(7, 32'hAB);
    exe_broadcast = 1'b1; exe_broadcast_map = 6'd7; exe_broadcast_val = 32'hAB;
    @(negedge CLK);
    exe_broadcast = 1'b0; busy[7] = 1'b0;
    waitQueue(0, 20);

    // Fill all eight slots with never-ready work, a ninth is dropped, then flush
    busy[30] = 1'b1;
    p_full = mk_pkt(32'h1, 5'd0, 32'h500, K_IMM | K_REGWR, 6'h09, 2'b00,
                    32'h4fc, 32'h27de0001, 5'd30, 5'd30, 5'd0);
    for (int k = 0; k < 8; k++)
      applyStimulus(p_full, 32'd100 + 32'(k), 6'd30, 6'd0, 6'd0);
    checkOutput("full_halt", 512'(halt_rename), 512'(1));
    p_drop = mk_pkt(32'h2, 5'd0, 32'h600, K_IMM, 6'h09, 2'b00,
                    32'h5fc, 32'h24000002, 5'd0, 5'd0, 5'd0);
    applyStimulus(p_drop, 32'd108, 6'd0, 6'd0, 6'd0);
    repeat (3) @(negedge CLK);
    checkOutput("full_halt_hold", 512'(halt_rename), 512'(1));
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    checkOutput("flush_halt", 512'(halt_rename), 512'(0));
    checkOutput("flush_out", 512'(dut_out), 512'(0));
    exe_broadcast = 1'b1; exe_broadcast_map = 6'd30; exe_broadcast_val = 32'h30;
    @(negedge CLK);
    exe_broadcast = 1'b0; busy[30] = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("post_flush_bubble", 512'(dut_out), 512'(0));

    // Store waits on data tag 9; MEM result is forwarded at issue
    busy[9] = 1'b1;
    p_st = mk_pkt(32'h4, 5'd0, 32'h704, K_MEMWR | K_IMM, 6'h20, 2'b00,
                  32'h700, 32'hafa90004, 5'd29, 5'd9, 5'd0);
    sb.push_back(mk_exp(p_st, 32'd200, 6'd9, 32'd0, 32'h4, 32'h55, 1'b0));
    applyStimulus(p_st, 32'd200, 6'd0, 6'd0, 6'd9);
    repeat (2) @(negedge CLK);
    mem_broadcast = 1'b1; mem_broadcast_map = 6'd9; mem_broadcast_val = 32'h55;
    repeat (2) @(negedge CLK);
    mem_broadcast = 1'b0; busy[9] = 1'b0;
    waitQueue(0, 20);

    // jal takes the packet constant for B even with regdst set, then STALL holds it
    p_jal = mk_pkt(32'h408, 5'd0, 32'h500, K_BRANCH | K_LINK | K_REGDST | K_REGWR, 6'h21, 2'b00,
                   32'h800, 32'h0c000140, 5'd0, 5'd6, 5'd31);
    e_jal = mk_exp(p_jal, 32'd300, 6'd31, 32'd0, 32'h408, 32'd0, 1'b1);
    sb.push_back(e_jal);
    applyStimulus(p_jal, 32'd300, 6'd0, 6'd6, 6'd31);
    @(negedge CLK);
    STALL = 1'b1;
    p_nx = mk_pkt(32'h0, 5'd0, 32'h808, K_REGDST | K_REGWR, 6'h21, 2'b00,
                  32'h804, 32'h00a64021, 5'd5, 5'd6, 5'd8);
    sb.push_back(mk_exp(p_nx, 32'd301, 6'd33, 32'd3, 32'd4, 32'd0, 1'b1));
    applyStimulus(p_nx, 32'd301, 6'd5, 6'd6, 6'd33);
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("stall_hold%0d", s), 512'(dut_out), 512'(e_jal));
      if (s < 2) @(negedge CLK);
    end
    STALL = 1'b0;
    waitQueue(0, 20);

    // Asynchronous reset while an output is held and a waiting entry is queued
    busy[40] = 1'b1;
    p_w = mk_pkt(32'h0, 5'd0, 32'h904, K_IMM | K_REGWR, 6'h09, 2'b00,
                 32'h900, 32'h24080000, 5'd8, 5'd8, 5'd8);
    p_r = mk_pkt(32'h5, 5'd0, 32'h908, K_IMM | K_REGWR, 6'h09, 2'b00,
                 32'h904, 32'h24090005, 5'd0, 5'd9, 5'd9);
    sb.push_back(mk_exp(p_r, 32'd401, 6'd41, 32'd0, 32'h5, 32'd0, 1'b1));
    applyStimulus(p_w, 32'd400, 6'd40, 6'd0, 6'd0);
    applyStimulus(p_r, 32'd401, 6'd0, 6'd0, 6'd41);
    waitQueue(0, 20);
    STALL = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("midreset_out", 512'(dut_out), 512'(0));
    checkOutput("midreset_halt", 512'(halt_rename), 512'(0));
    @(negedge CLK);
    RESET = 1'b1;
    STALL = 1'b0;
    exe_broadcast = 1'b1; exe_broadcast_map = 6'd40; exe_broadcast_val = 32'h40;
    @(negedge CLK);
    exe_broadcast = 1'b0; busy[40] = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("post_reset_empty", 512'(dut_out), 512'(0));

    repeat (3) @(negedge CLK);
    checkOutput("scoreboard_drained", 512'(sb.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
